// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] HALT_PC_DEFAULT  = 32'h8008_8008;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        RUN,
        HALT
    } fetch_state_t;

    // Clear the byte-offset bits so every fetch address is word aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush; DEPTH must be a power of two.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    output fetch_entry_t           pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Flush wins over any same-cycle push or pop.
    assign do_push = push && !flush;
    assign do_pop  = pop && !flush;

    // Pointer and occupancy tracking; pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && full && !pop && !flush));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
        !(pop && empty && !flush));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: credit-limited request issue, in-order response tracking,
// redirect with drop of stale responses, and a sticky halt at HALT_PC.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [31:0] HALT_PC    = HALT_PC_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] next_pc,
    output logic        halted
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam logic [SUM_W-1:0] DEPTH_C = SUM_W'(FIFO_DEPTH);

    fetch_state_t     state;
    logic [31:0]      pc_q;
    logic             run_en_q;
    logic             halted_q;
    logic [CNT_W-1:0] drop_q;
    logic [CNT_W-1:0] drop_d;

    // PCs of accepted, not-yet-returned requests that will be kept.
    logic [31:0]      pcq_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] pcq_wr;
    logic [PTR_W-1:0] pcq_rd;
    logic [CNT_W-1:0] pcq_cnt;

    fetch_entry_t     buf_in;
    fetch_entry_t     buf_out;
    logic             buf_full;
    logic             buf_empty;
    logic [CNT_W-1:0] buf_count;

    logic             at_halt_pc;
    logic             pop_if;
    logic             accept;
    logic             do_redirect;
    logic             rsp_keep;
    logic             pcq_push;
    logic [SUM_W-1:0] outstanding;
    logic [SUM_W-1:0] credit_used;

    assign at_halt_pc  = (pc_q == HALT_PC);
    assign pop_if      = !buf_empty && if_ready;
    // Dropped responses still occupy a credit until they arrive.
    assign outstanding = SUM_W'(drop_q) + SUM_W'(pcq_cnt);
    // Occupancy is taken after this cycle's dequeue so a steady stream needs no bubble.
    assign credit_used = outstanding + SUM_W'(buf_count) - SUM_W'(pop_if);

    // run_en_q holds off the first request until the first edge after reset release.
    assign imem_req_valid = run_en_q && (state == RUN) && !at_halt_pc && (credit_used < DEPTH_C);
    assign imem_req_addr  = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;
    assign do_redirect    = redirect_valid && (state == RUN) && !at_halt_pc;
    assign rsp_keep       = imem_rsp_valid && (drop_q == '0) && !do_redirect;
    assign pcq_push       = accept && !do_redirect;

    // Drop count: on redirect everything still in flight (plus a same-edge accept) is stale.
    always_comb begin
        drop_d = drop_q;
        if (do_redirect) begin
            drop_d = CNT_W'(outstanding + SUM_W'(accept) - SUM_W'(imem_rsp_valid));
        end else if (imem_rsp_valid && (drop_q != '0)) begin
            drop_d = drop_q - CNT_W'(1);
        end
    end

    // Run/halt control, fetch PC update and drop counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            pc_q     <= RESET_PC;
            run_en_q <= 1'b0;
            halted_q <= 1'b0;
            drop_q   <= '0;
        end else begin
            run_en_q <= 1'b1;
            drop_q   <= drop_d;
            case (state)
                RUN: begin
                    if (at_halt_pc) begin
                        state    <= HALT;
                        halted_q <= 1'b1;
                    end else if (do_redirect) begin
                        pc_q <= align_word(redirect_pc);
                    end else if (accept) begin
                        pc_q <= pc_q + 32'd4;
                    end
                end
                HALT: halted_q <= 1'b1;
            endcase
        end
    end

    // In-order PC queue pointers; a redirect discards it since those responses get dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcq_wr  <= '0;
            pcq_rd  <= '0;
            pcq_cnt <= '0;
        end else if (do_redirect) begin
            pcq_wr  <= '0;
            pcq_rd  <= '0;
            pcq_cnt <= '0;
        end else begin
            if (pcq_push) pcq_wr <= pcq_wr + PTR_W'(1);
            if (rsp_keep) pcq_rd <= pcq_rd + PTR_W'(1);
            pcq_cnt <= pcq_cnt + CNT_W'(pcq_push) - CNT_W'(rsp_keep);
        end
    end

    // PC queue storage.
    always_ff @(posedge clk) begin
        if (pcq_push) pcq_mem[pcq_wr] <= pc_q;
    end

    assign buf_in.pc    = pcq_mem[pcq_rd];
    assign buf_in.instr = imem_rsp_data;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (do_redirect),
        .push      (rsp_keep),
        .push_data (buf_in),
        .pop       (pop_if),
        .pop_data  (buf_out),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    assign if_valid = !buf_empty;
    assign if_instr = buf_out.instr;
    assign if_pc    = buf_out.pc;
    assign next_pc  = pc_q;
    assign halted   = halted_q;

    a_credit_holds: assert property (@(posedge clk) disable iff (!rst)
        !(rsp_keep && buf_full && !pop_if));
    a_pcq_bounded: assert property (@(posedge clk) disable iff (!rst)
        !(pcq_push && !rsp_keep && (pcq_cnt == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios push expected PCs, a monitor
// checks every decode handshake against the queue head.
module tb_fetch_stage;

    localparam logic [31:0] HALT = 32'h8008_8008;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] next_pc;
    logic        halted;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .next_pc        (next_pc),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          mem_lat = 1;
    int          hits;
    logic [31:0] mon_exp;
    logic [31:0] exp_q[$];
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] req_addr[$];
    int          req_cyc[$];
    int          dlv_cyc[$];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'hA5A5_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every decode handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && if_valid && if_ready) begin
            dlv_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_delivery: got pc %h, required none", if_pc);
            end else begin
                mon_exp = exp_q.pop_front();
                check("if_pc", if_pc, mon_exp);
                check("if_instr", if_instr, instr_of(mon_exp));
            end
        end
    end

    // Memory request side: log accepted requests and schedule their responses.
    always @(negedge clk) begin
        if (rst && imem_req_valid && imem_req_ready) begin
            req_addr.push_back(imem_req_addr);
            req_cyc.push_back(cyc);
            pend_addr.push_back(imem_req_addr);
            pend_due.push_back(cyc + mem_lat);
        end
    end

    // Memory response side: in order, no earlier than the scheduled cycle.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (rst && pend_addr.size() != 0 && pend_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_mem();
        imem_rsp_valid = 1'b0;
        pend_addr.delete();
        pend_due.delete();
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        clear_mem();
        exp_q.delete();
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #3;
        req_addr.delete();
        req_cyc.delete();
        dlv_cyc.delete();
        rst = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d still expected, required 0", name, exp_q.size());
            exp_q.delete();
        end
        if_ready = 1'b0;
    endtask

    task automatic wait_reqs(input string name, input int cnt, input int budget);
        int n = 0;
        while (req_addr.size() < cnt && n < budget) begin
            tick();
            n++;
        end
        check({name, "_req_count"}, 32'(req_addr.size()), 32'(cnt));
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        // Reset state and back-to-back streaming with 1-cycle memory.
        repeat (2) @(posedge clk);
        #2;
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_next_pc", next_pc, 32'h0);
        check("rst_halted", 32'(halted), 32'd0);
        mem_lat  = 1;
        if_ready = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        release_reset();
        wait_drain("A", 40);
        check("A_req_count_ok", 32'(req_addr.size() >= 3), 32'd1);
        check("A_req0", req_addr[0], 32'h0);
        check("A_req1", req_addr[1], 32'h4);
        check("A_req2", req_addr[2], 32'h8);
        check("A_req_gap1", 32'(req_cyc[1] - req_cyc[0]), 32'd1);
        check("A_req_gap2", 32'(req_cyc[2] - req_cyc[1]), 32'd1);
        check("A_dlv_gap1", 32'(dlv_cyc[1] - dlv_cyc[0]), 32'd1);
        check("A_dlv_gap2", 32'(dlv_cyc[2] - dlv_cyc[1]), 32'd1);

        // Decode stalled: credit limits in-flight plus buffered to the depth.
        apply_reset();
        mem_lat  = 1;
        if_ready = 1'b0;
        release_reset();
        repeat (6) tick();
        check("B_req_count", 32'(req_addr.size()), 32'd2);
        check("B_if_valid", 32'(if_valid), 32'd1);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        if_ready = 1'b1;
        wait_drain("B", 40);

        // Redirect with two responses in flight on a 3-cycle memory.
        apply_reset();
        mem_lat  = 3;
        if_ready = 1'b1;
        release_reset();
        wait_reqs("C", 2, 20);
        do_redirect(32'h0000_0100);
        check("C_next_pc", next_pc, 32'h0000_0100);
        exp_q.push_back(32'h0000_0100);
        exp_q.push_back(32'h0000_0104);
        wait_drain("C", 40);

        // Address wrap and redirect alignment.
        mem_lat = 1;
        do_redirect(32'hFFFF_FFFC);
        if_ready = 1'b1;
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        wait_drain("D_wrap", 40);
        do_redirect(32'h0000_0103);
        check("D_align_addr", imem_req_addr, 32'h0000_0100);
        if_ready = 1'b1;
        exp_q.push_back(32'h0000_0100);
        exp_q.push_back(32'h0000_0104);
        wait_drain("D_align", 40);

        // Run into the halt sentinel; later redirect must be ignored.
        do_redirect(32'h8008_7FF8);
        if_ready = 1'b1;
        exp_q.push_back(32'h8008_7FF8);
        exp_q.push_back(32'h8008_7FFC);
        exp_q.push_back(32'h8008_8000);
        exp_q.push_back(32'h8008_8004);
        wait_drain("E", 40);
        if_ready = 1'b1;
        repeat (4) tick();
        check("E_halted", 32'(halted), 32'd1);
        check("E_no_req_valid", 32'(imem_req_valid), 32'd0);
        check("E_next_pc", next_pc, HALT);
        hits = 0;
        for (int i = 0; i < req_addr.size(); i++) begin
            if (req_addr[i] == HALT) hits++;
        end
        check("E_no_halt_req", 32'(hits), 32'd0);
        do_redirect(32'h0000_0040);
        repeat (5) tick();
        check("E_redirect_ignored", next_pc, HALT);
        check("E_still_no_req", 32'(imem_req_valid), 32'd0);
        check("E_still_halted", 32'(halted), 32'd1);
        if_ready = 1'b0;

        // Asynchronous reset with two entries buffered.
        apply_reset();
        mem_lat  = 1;
        if_ready = 1'b0;
        release_reset();
        #1;
        check("F_no_early_req", 32'(imem_req_valid), 32'd0);
        repeat (6) tick();
        check("F_buffered", 32'(if_valid), 32'd1);
        check("F_pre_next_pc", next_pc, 32'h8);
        #1;
        rst = 1'b0;
        clear_mem();
        #1;
        check("F_async_if_valid", 32'(if_valid), 32'd0);
        check("F_async_next_pc", next_pc, 32'h0);
        check("F_async_req_valid", 32'(imem_req_valid), 32'd0);
        check("F_async_halted", 32'(halted), 32'd0);
        release_reset();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        if_ready = 1'b1;
        wait_drain("F", 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
